// File: rtl/rpn_uart_pkg.sv
// Shared constants, RX state encoding and ASCII-hex decode for the RPN UART front end.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none.
package rpn_uart_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_LOW_U = 8'h75;
    localparam logic [7:0] ASCII_UP_U  = 8'h55;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] val;
    } nibble_t;

    // '0'-'9', 'a'-'f', 'A'-'F' map to 0..15; anything else comes back with vld=0.
    function automatic nibble_t ascii_to_nibble(input logic [7:0] c);
        nibble_t n;
        n.vld = 1'b1;
        n.val = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            n.val = c[3:0];
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            n.val = c[3:0] + 4'd9;
        end else begin
            n.vld = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/rpn_uart_cmd_rx_if.sv
// Line-side and calculator-side signals of the serial command front end.
// Latency: none (wiring only).
// Backpressure: none; all outputs are pulses or levels, the receiver never stalls.
interface rpn_uart_cmd_rx_if;
    logic        rx;
    logic [15:0] DataOut;
    logic        EnterPulse;
    logic        UndoPulse;
    logic [15:0] Pending;
    logic        ErrPulse;
    logic        tx;

    // Environment side: drives the serial line, observes the command outputs.
    modport master (output rx, input DataOut, EnterPulse, UndoPulse, Pending, ErrPulse, tx);
    // Front-end side.
    modport slave  (input rx, output DataOut, EnterPulse, UndoPulse, Pending, ErrPulse, tx);
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchronizer, start-glitch rejection, mid-bit sampling.
// Latency: byte_valid/frame_err pulse at mid-stop-bit, ~9.5 bit times + 3 cycles after the start edge.
// Backpressure: none; each result is a single-cycle pulse and must be taken when offered.
module uart_rx_8n1
    import rpn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          meta_q, sync_q, prev_q, armed_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q;
    logic          vld_q, ferr_q;
    logic          start_edge;

    // armed_q blocks a start until the line has been seen high, so a line held low through reset is ignored.
    assign start_edge = armed_q && prev_q && !sync_q;

    // Synchronize rx and keep the previous sample for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            meta_q <= rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (sync_q) armed_q <= 1'b1;
        end
    end

    // Frame FSM: half-bit start check, 8 data samples LSB first, stop-bit check; counter clears on every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (start_edge) state_q <= START;
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        state_q <= sync_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shreg_q <= {sync_q, shreg_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (sync_q) vld_q  <= 1'b1;
                        else        ferr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_valid = vld_q;
    assign byte_data  = shreg_q;
    assign frame_err  = ferr_q;
endmodule

// File: rtl/rpn_uart_cmd_rx.sv
// Serial command front end: hex digits accumulate into Pending; CR/'=' enter, 'u'/'U' undo; optional echo (RPN_UART_ECHO_EN).
// Latency: command pulses and DataOut register 1 cycle after the received byte is validated.
// Backpressure: none; echoes that find the shifter and holding register both full are dropped.
module rpn_uart_cmd_rx
    import rpn_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic               clk,
    input  logic               reset,
    rpn_uart_cmd_rx_if.slave   bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic        rx_vld, rx_ferr;
    logic [7:0]  rx_byte;
    nibble_t     nib;
    logic [15:0] pending_q, dout_q;
    logic        enter_q, undo_q, err_q;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.rx),
        .byte_valid (rx_vld),
        .byte_data  (rx_byte),
        .frame_err  (rx_ferr)
    );

    assign nib = ascii_to_nibble(rx_byte);

    // Command parser; rx_vld and rx_ferr never coincide, so at most one pulse fires per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            dout_q    <= '0;
            enter_q   <= 1'b0;
            undo_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            enter_q <= 1'b0;
            undo_q  <= 1'b0;
            err_q   <= rx_ferr;
            if (rx_vld) begin
                if (nib.vld) begin
                    pending_q <= {pending_q[11:0], nib.val};
                end else begin
                    case (rx_byte)
                        ASCII_CR, ASCII_EQ: begin
                            dout_q    <= pending_q;
                            pending_q <= '0;
                            enter_q   <= 1'b1;
                        end
                        ASCII_LOW_U, ASCII_UP_U: undo_q <= 1'b1;
                        ASCII_BS:  pending_q <= {4'h0, pending_q[15:4]};
                        ASCII_ESC: pending_q <= '0;
                        ASCII_LF:  begin end
                        default:   err_q <= 1'b1;
                    endcase
                end
            end
        end
    end

    assign bus.DataOut    = dout_q;
    assign bus.Pending    = pending_q;
    assign bus.EnterPulse = enter_q;
    assign bus.UndoPulse  = undo_q;
    assign bus.ErrPulse   = err_q;

`ifdef RPN_UART_ECHO_EN
    localparam int TCW = $clog2(CLKS_PER_BIT);

    logic           hold_vld_q, tx_busy_q, tx_q, tx_load;
    logic [7:0]     hold_q;
    logic [9:0]     txsh_q;
    logic [3:0]     tx_idx_q;
    logic [TCW-1:0] tx_cnt_q;

    assign tx_load = hold_vld_q && !tx_busy_q;

    // One-entry holding register; it also accepts in the cycle it drains into the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (rx_vld && (!hold_vld_q || tx_load)) begin
            hold_vld_q <= 1'b1;
            hold_q     <= rx_byte;
        end else if (tx_load) begin
            hold_vld_q <= 1'b0;
        end
    end

    // 8N1 shifter: start, 8 data LSB first, stop; tx is registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy_q <= 1'b0;
            txsh_q    <= '1;
            tx_idx_q  <= '0;
            tx_cnt_q  <= '0;
            tx_q      <= 1'b1;
        end else begin
            tx_q <= tx_busy_q ? txsh_q[0] : 1'b1;
            if (tx_load) begin
                txsh_q    <= {1'b1, hold_q, 1'b0};
                tx_busy_q <= 1'b1;
                tx_idx_q  <= '0;
                tx_cnt_q  <= '0;
            end else if (tx_busy_q) begin
                if (tx_cnt_q == TCW'(CLKS_PER_BIT - 1)) begin
                    tx_cnt_q <= '0;
                    if (tx_idx_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                    end else begin
                        tx_idx_q <= tx_idx_q + 1'b1;
                        txsh_q   <= {1'b1, txsh_q[9:1]};
                    end
                end else begin
                    tx_cnt_q <= tx_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.tx = tx_q;
`else
    assign bus.tx = 1'b1;
`endif
endmodule

// File: tb/tb_rpn_uart_cmd_rx.sv
// Randomized and directed bench for rpn_uart_cmd_rx with a command-level reference model.
// Latency: frames take 100 cycles at 10 clocks per bit; results are checked at frame end and every cycle.
// Backpressure: none; the bench drives the line freely, back-to-back where it chooses.
`timescale 1ns/1ps
module tb_rpn_uart_cmd_rx;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rpn_uart_cmd_rx_if bus();

    rpn_uart_cmd_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          kind;   // 1 enter, 2 undo, 3 error
        logic [15:0] data;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        exp_q[$];
    logic [7:0]  echo_q[$];
    logic [15:0] mdl_pend = 16'h0;
    logic [15:0] cur_dout = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model of the command layer: what each accepted byte does to Pending and which pulse it raises.
    task automatic mdl_byte(input logic [7:0] b);
        int nib;
        nib = -1;
        if (b >= "0" && b <= "9") nib = int'(b) - 48;
        else if (b >= "a" && b <= "f") nib = int'(b) - 87;
        else if (b >= "A" && b <= "F") nib = int'(b) - 55;
        if (nib >= 0) begin
            mdl_pend = (mdl_pend << 4) | 16'(nib);
        end else if (b == 8'h0D || b == "=") begin
            exp_q.push_back(exp_t'{kind: 1, data: mdl_pend});
            mdl_pend = 16'h0;
        end else if (b == "u" || b == "U") begin
            exp_q.push_back(exp_t'{kind: 2, data: 16'h0});
        end else if (b == 8'h08) begin
            mdl_pend = mdl_pend >> 4;
        end else if (b == 8'h1B) begin
            mdl_pend = 16'h0;
        end else if (b != 8'h0A) begin
            exp_q.push_back(exp_t'{kind: 3, data: 16'h0});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called at posedge+2; returns at posedge+2 at the end of the stop bit (or after the reset abort).
    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input int abort_bit = -1);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        if (abort_bit < 0) begin
            if (stop_ok) begin
                mdl_byte(b);
                echo_q.push_back(b);
            end else begin
                exp_q.push_back(exp_t'{kind: 3, data: 16'h0});
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                reset = 1'b1;
                mdl_pend = 16'h0;
                cur_dout = 16'h0;
                exp_q.delete();
                idle(3);
                check("rst_dataout", bus.DataOut, 16'h0000);
                check("rst_pending", bus.Pending, 16'h0000);
                check("rst_pulses", {bus.EnterPulse, bus.UndoPulse, bus.ErrPulse}, 3'b000);
                check("rst_tx", bus.tx, 1'b1);
                bus.rx = 1'b1;
                reset = 1'b0;
                idle(30);
                return;
            end
            bus.rx = fr[i];
            idle(CPB);
        end
        if (stop_ok) begin
            check("pending", bus.Pending, mdl_pend);
        end else begin
            bus.rx = 1'b1;
            idle(CPB);
            check("pending_after_ferr", bus.Pending, mdl_pend);
        end
    endtask

    // Every cycle out of reset: pulse exclusivity, pulse order/kind against the model, DataOut stability.
    initial begin
        int   np;
        int   kind;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                np = int'(bus.EnterPulse) + int'(bus.UndoPulse) + int'(bus.ErrPulse);
                check("pulse_exclusive", np <= 1, 1'b1);
                if (np == 1) begin
                    kind = bus.EnterPulse ? 1 : (bus.UndoPulse ? 2 : 3);
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse_kind", kind, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", kind, e.kind);
                        if (kind == 1) begin
                            check("enter_dataout", bus.DataOut, e.data);
                            cur_dout = e.data;
                        end
                    end
                end
                check("dataout_stable", bus.DataOut, cur_dout);
`ifndef RPN_UART_ECHO_EN
                check("tx_idle", bus.tx, 1'b1);
`endif
            end
        end
    end

`ifdef RPN_UART_ECHO_EN
    // Decode the echo line at mid-bit and compare against bytes that passed the framing check.
    initial begin
        logic [7:0] got;
        forever begin
            @(negedge bus.tx);
            repeat (CPB / 2) @(posedge clk);
            #1 check("echo_start", bus.tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                #1 got[i] = bus.tx;
            end
            repeat (CPB) @(posedge clk);
            #1 check("echo_stop", bus.tx, 1'b1);
            if (echo_q.size() == 0) check("echo_unexpected", echo_q.size(), 1);
            else check("echo_byte", got, echo_q.pop_front());
        end
    end
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] b;
        int         r, n;
        bus.rx = 1'b1;
        reset  = 1'b1;
        idle(5);
        check("reset_dataout", bus.DataOut, 16'h0000);
        check("reset_pending", bus.Pending, 16'h0000);
        check("reset_pulses", {bus.EnterPulse, bus.UndoPulse, bus.ErrPulse}, 3'b000);
        check("reset_tx", bus.tx, 1'b1);
        reset = 1'b0;
        idle(20);

        // Four digits then CR.
        send_byte("1"); send_byte("2"); send_byte("a"); send_byte("F");
        check("lit_pend_12af", bus.Pending, 16'h12AF);
        send_byte(8'h0D);
        check("lit_dout_12af", bus.DataOut, 16'h12AF);
        check("lit_pend_clear", bus.Pending, 16'h0000);

        // Fifth digit pushes out the oldest; undo leaves DataOut alone.
        send_byte("1"); send_byte("2"); send_byte("3"); send_byte("4"); send_byte("5");
        send_byte(8'h0D);
        check("lit_dout_2345", bus.DataOut, 16'h2345);
        send_byte("u");
        check("lit_undo_dout", bus.DataOut, 16'h2345);
        send_byte("7"); send_byte(8'h08); send_byte(8'h08); send_byte(8'h0D);
        check("lit_dout_0000", bus.DataOut, 16'h0000);

        // Framing error and unrecognised character leave Pending untouched.
        send_byte("3");
        send_byte("Q", 1'b0);
        send_byte("x");
        check("lit_pend_after_err", bus.Pending, 16'h0003);

        // Short low glitch: no byte, no error.
        bus.rx = 1'b0;
        idle(3);
        bus.rx = 1'b1;
        idle(40);
        check("lit_pend_after_glitch", bus.Pending, 16'h0003);
        send_byte(8'h1B);
        send_byte(8'h0A);

        // Reset during bit 4 of a '5' frame.
        idle(150);
        send_byte("5", 1'b1, 4);
        send_byte("6");
        send_byte(8'h0D);
        check("lit_dout_0006", bus.DataOut, 16'h0006);

        // Back-to-back pair, then clear.
        send_byte("A");
        send_byte("B");
        check("lit_pend_ab", bus.Pending, 16'h00AB);
        send_byte(8'h1B);

        // Random command stream with random gaps.
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 15);
            n = $urandom_range(0, 15);
            if (r <= 5) begin
                if (n < 10) b = 8'(48 + n);
                else if ($urandom_range(0, 1) == 1) b = 8'(87 + n);
                else b = 8'(55 + n);
            end else if (r == 6) b = 8'h0D;
            else if (r == 7) b = "=";
            else if (r == 8) b = ($urandom_range(0, 1) == 1) ? "u" : "U";
            else if (r == 9) b = 8'h08;
            else if (r == 10) b = 8'h1B;
            else if (r == 11) b = 8'h0A;
            else b = 8'($urandom_range(0, 255));
            send_byte(b, r != 13);
            if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 20));
        end

        idle(250);
        check("pulses_all_seen", exp_q.size(), 0);
`ifdef RPN_UART_ECHO_EN
        check("echo_all_seen", echo_q.size(), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rpn_uart_cmd_rx.md
# rpn_uart_cmd_rx

Serial command front end for the RPN calculator. It receives 8N1 ASCII over a UART line and parses hex digits into a 16-bit operand. It emits single-cycle Enter and Undo pulses with a stable data word, so a PC terminal can drive the calculator in place of the switch bank and push buttons. It sits ahead of the calculator FSM, in parallel with the button level-to-pulse path.

## Interface
Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, ≥ 4 required)

Ports:
- clk  in  1  system clock; one clock domain; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rx  in  1  UART line, asynchronous to clk, idle high
- DataOut  out  16  operand word presented to the calculator DataIn; reset 16'h0000
- EnterPulse  out  1  one-cycle pulse per Enter command; reset 0
- UndoPulse  out  1  one-cycle pulse per Undo command; reset 0
- Pending  out  16  live digit accumulator, for optional display; reset 16'h0000
- ErrPulse  out  1  one-cycle pulse on framing error or unrecognised character; reset 0
- tx  out  1  echo line; constant 1 unless RPN_UART_ECHO_EN is defined; reset 1

## Operation
- rx passes through a 2-flop synchronizer. The previous-sample register resets to 1.
- Start detection: a falling edge on the synchronized rx while in IDLE. If the line is held low through reset, no frame starts until it has returned high.
- RX FSM states:
  - IDLE → START on the falling edge.
  - START: wait CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample 8 bits at CLKS_PER_BIT intervals, LSB first.
  - STOP: sample after a further CLKS_PER_BIT. A sample of 1 gives byte_valid for one cycle. A sample of 0 discards the byte and pulses ErrPulse.
  - STOP always returns to IDLE.
- Parser acts on each byte_valid:
  - '0'-'9', 'a'-'f', 'A'-'F' → Pending = {Pending[11:0], nibble}. Digits beyond four shift out the oldest.
  - 0x0D (CR) or '=' → DataOut ← Pending, EnterPulse, Pending ← 0.
  - 'u' or 'U' → UndoPulse. Pending and DataOut are unchanged.
  - 0x08 (BS) → Pending = {4'h0, Pending[15:4]}.
  - 0x1B (ESC) → Pending ← 0.
  - 0x0A (LF) → ignored with no error, so CRLF terminals work.
  - Any other byte → ErrPulse. State is unchanged.
- DataOut changes only on Enter and holds until the next Enter. It is therefore stable across the calculator's load cycles after the pulse. OpCodes are entered the same way; the calculator uses DataOut[1:0].
- At most one of EnterPulse, UndoPulse, ErrPulse is high in any cycle.

## Timing
- byte_valid rises at mid-stop-bit, about 9.5 bit times after the start edge, plus 2 cycles for the synchronizer.
- Command outputs register exactly 1 cycle after byte_valid. DataOut updates in the same cycle that EnterPulse is high.
- Pulses are exactly 1 cycle wide, whatever the baud rate.
- A new start edge is accepted from the first IDLE cycle after STOP. Back-to-back frames with a single stop bit must be received without loss.
- Reset mid-frame: the FSM returns to IDLE next cycle, the partial byte is discarded, and all outputs take their reset values. No pulse is emitted for the aborted frame.
- Bit-period counter width is $clog2(CLKS_PER_BIT). The counter reloads to 0 at every state transition.

## Configuration
- RPN_UART_ECHO_EN defined:
  - An 8N1 transmitter at the same BAUD echoes every byte that passes the framing check, including rejected characters.
  - Echoes queue in a 1-entry holding register behind the byte in flight.
  - If a byte arrives while both the TX shifter and the holding register are full, the new echo is dropped. Reception is never stalled.
  - tx is idle high; reset aborts transmission and drives tx high.
- Not defined: no transmitter logic is built, and tx is tied to 1.

## Structure
- Shared package rpn_uart_pkg holds:
  - the ASCII constants: CR, LF, BS, ESC, '=', 'u', 'U'
  - the RX state enum {IDLE, START, DATA, STOP}
  - the function ascii_to_nibble, which returns a valid bit and a 4-bit value.
- Sub-module uart_rx_8n1 holds the synchronizer, bit timing and RX FSM, with outputs byte_valid, byte_data and frame_err. The parser and the optional echo TX live in the top.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (10 clocks per bit).
- Send '1','2','a','F', CR → Pending 16'h12AF after the 4th byte; EnterPulse high for 1 cycle with DataOut=16'h12AF; Pending back to 0.
- Send '1','2','3','4','5', CR → DataOut=16'h2345. Then send '7', BS, BS, CR → DataOut=16'h0000.
- Send 'u' → UndoPulse for 1 cycle; DataOut unchanged; no EnterPulse.
- Send a frame with stop bit 0, then 'x' → two ErrPulses; Pending unchanged. A 3-cycle low glitch on rx → no byte, no error.
- Assert reset at bit 4 of a '5' frame, then send '6', CR → DataOut=16'h0006; no pulse from the aborted frame.
- With RPN_UART_ECHO_EN, send "AB" back-to-back → tx reproduces 0x41 then 0x42, bit-exact. Without the macro, tx stays 1 throughout.
